// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; MEM-stage resolution trains the table at the clock edge.
module branch_predictor #(
  parameter int PC_W    = 8,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              flush,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;

  logic [IDX_W-1:0]  f_idx, u_idx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  logic              f_hit, u_hit;
  logic [1:0]        upd_ctr_d;

  // Byte-offset bits of word-aligned PCs carry no information.
  logic              unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[PC_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[PC_W-1:IDX_W+2];

  always_comb begin
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && ctr_q[f_idx][1];
    pred_target = pred_taken ? target_q[f_idx] : fetch_pc + PC_W'(4);
  end

  always_comb begin
    mispredict = upd_valid &&
                 ((upd_pred_taken != upd_taken) ||
                  (upd_taken && (upd_target != upd_pred_target)));
  end

  always_comb begin
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    upd_ctr_d = ctr_q[u_idx];
    if (upd_taken) begin
      if (ctr_q[u_idx] != 2'b11) upd_ctr_d = ctr_q[u_idx] + 2'd1;
    end else begin
      if (ctr_q[u_idx] != 2'b00) upd_ctr_d = ctr_q[u_idx] - 2'd1;
    end
  end

  // Flush takes priority over a same-cycle update; the table is left untouched apart from valids.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= upd_ctr_d;
        if (upd_taken) target_q[u_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (upd_valid && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (mispredict && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a table-level reference model checked every cycle,
// plus literal expectations from hand-worked scenarios. A second instance uses 2-bit counters.
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic       flush, upd_valid, upd_taken, upd_pred_taken;
  logic [7:0] fetch_pc, upd_pc, upd_target, upd_pred_target;

  logic        pt1, mp1, pt2, mp2;
  logic [7:0]  ptg1, ptg2;
  logic [15:0] bc1, mc1;
  logic [1:0]  bc2, mc2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(8), .ENTRIES(ENTRIES), .CNT_W(16)) dut (
    .SYS_clk(clk), .SYS_reset(rst_n), .flush(flush), .fetch_pc(fetch_pc),
    .pred_taken(pt1), .pred_target(ptg1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mp1), .branch_count(bc1), .mispredict_count(mc1)
  );

  branch_predictor #(.PC_W(8), .ENTRIES(ENTRIES), .CNT_W(2)) dut2 (
    .SYS_clk(clk), .SYS_reset(rst2_n), .flush(flush), .fetch_pc(fetch_pc),
    .pred_taken(pt2), .pred_target(ptg2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mp2), .branch_count(bc2), .mispredict_count(mc2)
  );

  // Reference model: one record per table slot, integers throughout.
  bit m_valid  [ENTRIES];
  int m_tag    [ENTRIES];
  int m_target [ENTRIES];
  int m_ctr    [ENTRIES];
  int m_bc = 0, m_mc = 0, m_bc2 = 0, m_mc2 = 0;

  function automatic int slot_of(int pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int tag_of(int pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_pred_taken(int pc);
    int s = slot_of(pc);
    return m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
  endfunction

  function automatic int m_pred_target(int pc);
    if (m_pred_taken(pc)) return m_target[slot_of(pc)];
    return (pc + 4) % 256;
  endfunction

  function automatic bit m_mispredict();
    if (!upd_valid) return 1'b0;
    if (upd_pred_taken != upd_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 0;
      end
      m_bc = 0; m_mc = 0;
    end else begin
      int s;
      bit hit;
      s   = slot_of(int'(upd_pc));
      hit = m_valid[s] && (m_tag[s] == tag_of(int'(upd_pc)));
      if (upd_valid && m_bc < 65535) m_bc = m_bc + 1;
      if (m_mispredict() && m_mc < 65535) m_mc = m_mc + 1;
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (upd_valid) begin
        if (hit && upd_taken) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_target[s] = int'(upd_target);
        end else if (hit) begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end else if (upd_taken) begin
          m_valid[s] = 1'b1; m_tag[s] = tag_of(int'(upd_pc));
          m_target[s] = int'(upd_target); m_ctr[s] = 2;
        end
      end
    end
  end

  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) begin
      m_bc2 = 0; m_mc2 = 0;
    end else begin
      if (upd_valid && m_bc2 < 3) m_bc2 = m_bc2 + 1;
      if (m_mispredict() && m_mc2 < 3) m_mc2 = m_mc2 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_pred_taken",  32'(pt1),  32'(m_pred_taken(int'(fetch_pc))));
      chk("cyc_pred_target", 32'(ptg1), 32'(m_pred_target(int'(fetch_pc))));
      chk("cyc_mispredict",  32'(mp1),  32'(m_mispredict()));
      chk("cyc_branch_cnt",  32'(bc1),  32'(m_bc));
      chk("cyc_mispred_cnt", 32'(mc1),  32'(m_mc));
    end
    if (rst2_n) begin
      chk("cyc2_mispredict",  32'(mp2), 32'(m_mispredict()));
      chk("cyc2_branch_cnt",  32'(bc2), 32'(m_bc2));
      chk("cyc2_mispred_cnt", 32'(mc2), 32'(m_mc2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int pc, input bit tk, input int tgt, input bit ptk, input int ptgt);
    upd_valid = 1'b1; upd_pc = 8'(pc); upd_taken = tk; upd_target = 8'(tgt);
    upd_pred_taken = ptk; upd_pred_target = 8'(ptgt); flush = 1'b0;
  endtask

  task automatic idle();
    upd_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic look(input int pc, input bit exp_pt, input int exp_tgt, input string tag);
    fetch_pc = 8'(pc);
    #1;
    chk({tag, "_pt"},  32'(pt1),  32'(exp_pt));
    chk({tag, "_tgt"}, 32'(ptg1), 32'(exp_tgt));
  endtask

  int v_pc   [8] = '{'h14, 'h14, 'h94, 'h14, 'h94, 'hFC, 'hFC, 'h28};
  bit v_tk   [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  int v_tgt  [8] = '{'h80, 'h80, 'hC0, 'h80, 'hC0, 'h00, 'h00, 'h00};
  bit v_ptk  [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
  int v_ptgt [8] = '{'h18, 'h80, 'h98, 'h18, 'hC0, 'h00, 'h00, 'h2C};

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    idle();
    upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    look('h10, 1'b0, 'h14, "reset_lookup");
    chk("reset_bc", 32'(bc1), 32'd0);
    chk("reset_mc", 32'(mc1), 32'd0);
    tick(); tick();
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();

    // First taken branch allocates; same cycle still sees the empty table.
    upd('h10, 1, 'h40, 0, 'h14);
    look('h10, 1'b0, 'h14, "alloc_same_cycle");
    chk("alloc_mispredict", 32'(mp1), 32'd1);
    tick(); idle();
    look('h10, 1'b1, 'h40, "alloc_next");
    chk("alloc_bc", 32'(bc1), 32'd1);
    chk("alloc_mc", 32'(mc1), 32'd1);

    repeat (3) begin
      upd('h10, 1, 'h40, 1, 'h40);
      #1 chk("taken_no_mp", 32'(mp1), 32'd0);
      tick();
    end
    idle();
    look('h10, 1'b1, 'h40, "sat_hi");
    chk("sat_hi_bc", 32'(bc1), 32'd4);
    chk("sat_hi_mc", 32'(mc1), 32'd1);

    upd('h10, 0, 'h40, 1, 'h40); tick(); idle();
    look('h10, 1'b1, 'h40, "ctr2_still_taken");
    upd('h10, 0, 'h40, 1, 'h40); tick(); idle();
    look('h10, 1'b0, 'h14, "ctr1_not_taken");
    chk("ctr1_bc", 32'(bc1), 32'd6);
    chk("ctr1_mc", 32'(mc1), 32'd3);

    // Down to ctr=0; a following taken update must hit (ctr 1), not re-allocate (ctr 2).
    upd('h10, 0, 'h40, 0, 'h14); tick();
    upd('h10, 1, 'h40, 0, 'h14); tick(); idle();
    look('h10, 1'b0, 'h14, "ctr0_still_valid");
    upd('h10, 1, 'h40, 0, 'h14); tick(); idle();
    look('h10, 1'b1, 'h40, "ctr_back_to_2");
    chk("ctr2_bc", 32'(bc1), 32'd9);
    chk("ctr2_mc", 32'(mc1), 32'd5);

    upd('h50, 1, 'h80, 0, 'h54); tick(); idle();
    look('h10, 1'b0, 'h14, "alias_evicted");
    look('h50, 1'b1, 'h80, "alias_new");
    look('hFC, 1'b0, 'h00, "wrap");

    upd('h50, 0, 'h80, 1, 'h80);
    look('h50, 1'b1, 'h80, "concurrent_old");
    tick(); idle();
    look('h50, 1'b0, 'h54, "concurrent_after");

    upd('h50, 1, 'h90, 1, 'h80);
    #1 chk("target_mismatch_mp", 32'(mp1), 32'd1);
    tick(); idle();
    look('h50, 1'b1, 'h90, "retarget");

    upd('h24, 1, 'h30, 0, 'h28); tick(); idle();
    look('h24, 1'b1, 'h30, "alloc_24");

    upd('h60, 1, 'hA0, 0, 'h64); flush = 1'b1;
    tick(); idle();
    look('h50, 1'b0, 'h54, "flush_50");
    look('h24, 1'b0, 'h28, "flush_24");
    look('h60, 1'b0, 'h64, "flush_60");
    chk("flush_bc", 32'(bc1), 32'd14);
    tick();

    for (int i = 0; i < 8; i++) begin
      fetch_pc = 8'(v_pc[i]);
      upd(v_pc[i], v_tk[i], v_tgt[i], v_ptk[i], v_ptgt[i]);
      tick();
    end
    idle();
    tick();

    // 2-bit counters on the second instance.
    #1 rst2_n = 1'b0;
    #1 chk("cnt2_reset_bc", 32'(bc2), 32'd0);
    chk("cnt2_reset_mc", 32'(mc2), 32'd0);
    #1 rst2_n = 1'b1;
    tick();
    repeat (5) begin
      upd('h34, 1, 'h44, 0, 'h38);
      tick();
    end
    idle();
    #1 chk("cnt2_sat_bc", 32'(bc2), 32'd3);
    chk("cnt2_sat_mc", 32'(mc2), 32'd3);
    tick();
    upd('h34, 1, 'h44, 0, 'h38); tick();
    #1 rst2_n = 1'b0;
    #1 chk("cnt2_midreset_bc", 32'(bc2), 32'd0);
    chk("cnt2_midreset_mc", 32'(mc2), 32'd0);
    idle();
    #1 rst2_n = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
